// File: rtl/fadd_issue_ctrl_pkg.sv
// Shared FPU definitions: FP32 field positions, adder latency, op encodings and result record.
package fadd_issue_ctrl_pkg;

  localparam int unsigned FP32_SIGN    = 31;
  localparam int unsigned FP32_EXP_MSB = 30;
  localparam int unsigned FP32_EXP_LSB = 23;
  localparam int unsigned FP32_MAN_MSB = 22;
  localparam int unsigned FP32_MAN_LSB = 0;

  localparam int unsigned FADD_LAT  = 2;
  localparam int unsigned FPU_TAG_W = 5;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } fadd_op_e;

  typedef struct packed {
    logic [31:0]          y;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_result_t;

  // Subtraction is an add with the second operand's sign flipped.
  function automatic logic [31:0] fp32_apply_op(input logic [31:0] x, input logic op);
    return {x[FP32_SIGN] ^ (op == OpSub),
            x[FP32_EXP_MSB:FP32_EXP_LSB],
            x[FP32_MAN_MSB:FP32_MAN_LSB]};
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// First-word-fall-through result FIFO with synchronous flush and occupancy count.
module fpu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_pop;

  assign valid  = (count_q != '0);
  assign do_pop = pop & valid;
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  // Callers guarantee a free slot for every push, so push is not gated on full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fadd_issue_ctrl.sv
// Valid/ready issue wrapper for the pipelined FP32 adder: tag pipe, credit check and result FIFO.
module fadd_issue_ctrl
  import fadd_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = FPU_TAG_W,
  parameter int unsigned LAT   = FADD_LAT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic [31:0]            in_x1,
  input  logic [31:0]            in_x2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [31:0]            fa_x1,
  output logic [31:0]            fa_x2,
  input  logic [31:0]            fa_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_y,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned ResW = 32 + TAG_W;
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  logic [LAT-1:0]   pipe_vld_q;
  logic [TAG_W-1:0] pipe_tag_q [LAT];
  logic [CntW:0]    inflight;
  logic [CntW:0]    credit_sum;
  logic             accept;
  logic [ResW-1:0]  push_data;
  logic [ResW-1:0]  head;

  assign fa_x1 = in_x1;
  assign fa_x2 = fp32_apply_op(in_x2, in_op);

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight = inflight + (CntW + 1)'(pipe_vld_q[i]);
    end
  end

  // Every in-flight op already owns a FIFO slot; a same-cycle pop is deliberately not credited.
  assign credit_sum = {1'b0, count} + inflight;
  assign in_ready   = !flush && (credit_sum < DepthLim);
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_tag_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= accept;
      pipe_tag_q[0] <= in_tag;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1] & ~flush;
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
    end
  end

  assign push_data = {fa_y, pipe_tag_q[LAT-1]};

  fpu_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ResW)
  ) u_result_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (pipe_vld_q[LAT-1]),
    .push_data (push_data),
    .pop       (out_ready),
    .valid     (out_valid),
    .head      (head),
    .count     (count)
  );

  assign out_y   = head[ResW-1:TAG_W];
  assign out_tag = head[TAG_W-1:0];

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Scoreboard bench for fadd_issue_ctrl with a behavioural 2-cycle FP32 adder in the loop.
module tb_fadd_issue_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_op;
  logic [31:0]            in_x1;
  logic [31:0]            in_x2;
  logic [TAG_W-1:0]       in_tag;
  logic [31:0]            fa_x1;
  logic [31:0]            fa_x2;
  logic [31:0]            fa_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_y;
  logic [TAG_W-1:0]       out_tag;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;

  always #5 clk = ~clk;

  fadd_issue_ctrl #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .LAT   (2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .fa_x1     (fa_x1),
    .fa_x2     (fa_x2),
    .fa_y      (fa_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .count     (count)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural adder: operands captured at edge k, sum on fa_y after edge k+1.
  logic [31:0] add_s1_x1, add_s1_x2;
  always @(posedge clk) begin
    add_s1_x1 <= fa_x1;
    add_s1_x2 <= fa_x2;
    fa_y      <= r2f(f2r(add_s1_x1) + f2r(add_s1_x2));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  always @(negedge clk) begin
    if (rstn) begin
      check("count_bound", 64'(int'(count) <= int'(DEPTH)), 64'd1);
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_y", 64'(out_y), 64'(e.y));
          check("out_tag", 64'(out_tag), 64'(e.tag));
          pops++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic op, input logic [31:0] x1, input logic [31:0] x2,
                           input logic [TAG_W-1:0] tag, input logic [31:0] y_req,
                           input logic [31:0] fa2_req);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_x1    = x1;
    in_x2    = x2;
    in_tag   = tag;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        check("fa_x1", 64'(fa_x1), 64'(x1));
        check("fa_x2", 64'(fa_x2), 64'(fa2_req));
        exp_q.push_back('{y: y_req, tag: tag});
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) fail_now("issue_timeout");
  endtask

  // Backpressure operands: x1 = 1.0..6.0, x2 = 1.0, results 2.0..7.0.
  logic [31:0] bp_x1 [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] bp_y  [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int pops0;
    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_x1     = '0;
    in_x2     = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    #10;
    rstn = 1'b1;
    tick();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Add with latency check.
    out_ready = 1'b1;
    issue_one(1'b0, 32'h3F800000, 32'h40000000, 5'd3, 32'h40400000, 32'h40000000);
    @(negedge clk);
    check("lat_k0", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_k1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_k2", 64'(out_valid), 64'd1);
    check("lat_count", 64'(count), 64'd1);
    repeat (3) tick();
    check("add_drain", 64'(exp_q.size()), 64'd0);

    // Subtract.
    issue_one(1'b1, 32'h40400000, 32'h3F800000, 5'd7, 32'h40000000, 32'hBF800000);
    repeat (5) tick();
    check("sub_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: only DEPTH ops fit while writeback is stalled.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_op    = 1'b0;
      in_x1    = bp_x1[acc];
      in_x2    = 32'h3F800000;
      in_tag   = TAG_W'(acc);
      @(negedge clk);
      if (acc == 4) check("bp_ready_low", 64'(in_ready), 64'd0);
      if (in_ready) begin
        exp_q.push_back('{y: bp_y[acc], tag: TAG_W'(acc)});
        acc++;
      end
      tick();
    end
    check("bp_accepted", 64'(acc), 64'd4);
    check("bp_count_full", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 6; c++) begin
      in_valid = 1'b1;
      in_x1    = bp_x1[acc];
      in_tag   = TAG_W'(acc);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{y: bp_y[acc], tag: TAG_W'(acc)});
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_resume", 64'(acc), 64'd6);
    repeat (8) tick();
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // Streaming: one op and one result per cycle.
    pops0 = pops;
    for (int i = 0; i < 20; i++) begin
      real a, b;
      a        = real'(i + 1);
      b        = 0.25 * real'(i);
      in_valid = 1'b1;
      in_op    = 1'(i % 2);
      in_x1    = r2f(a);
      in_x2    = r2f(b);
      in_tag   = TAG_W'(i);
      @(negedge clk);
      check("stream_ready", 64'(in_ready), 64'd1);
      if (i >= 3) check("stream_out_valid", 64'(out_valid), 64'd1);
      if (in_ready) exp_q.push_back('{y: r2f((i % 2 == 1) ? a - b : a + b), tag: TAG_W'(i)});
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    check("stream_pops", 64'(pops - pops0), 64'd20);
    check("stream_drain", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with ops in flight.
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_x1    = 32'h3F800000;
    in_x2    = 32'h3F800000;
    in_tag   = 5'd10;
    tick();
    in_tag = 5'd11;
    tick();
    in_valid = 1'b0;
    rstn     = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("arst_no_stale", 64'(out_valid), 64'd0);
    end
    tick();

    // Flush with three buffered results and one in flight.
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1;
      in_x1    = bp_x1[t];
      in_x2    = 32'h3F800000;
      in_tag   = TAG_W'(t + 20);
      @(negedge clk);
      check("fl_fill_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("fl_pre_count", 64'(count), 64'd3);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("fl_ready_low", 64'(in_ready), 64'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_count", 64'(count), 64'd0);
    @(negedge clk);
    check("fl_ready_back", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("fl_no_stale", 64'(out_valid), 64'd0);
    end
    tick();

    // Normal operation after flush.
    issue_one(1'b0, 32'h3F800000, 32'h3F800000, 5'd9, 32'h40000000, 32'h3F800000);
    repeat (5) tick();
    check("post_flush_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
